// File: rtl/dr_rx_check_if.sv
`default_nettype none
// ============================================================================
// Module   : dr_rx_check_if
// Purpose  : Dual-rail bus in, decoded single-rail word and strobes out.
//            The producer side drives the rails; the checker side returns
//            the decoded word, its valid strobe and the violation strobe.
// Revision : 1.0 - initial release
// ============================================================================
interface dr_rx_check_if #(
  parameter int W = 8
);
  logic [W-1:0] D_1;   // true rails
  logic [W-1:0] D_0;   // false rails
  logic [W-1:0] Q;     // decoded word
  logic         QV;    // Q updated this cycle
  logic         ERR;   // protocol violation this cycle

  modport master (
    output D_1,
    output D_0,
    input  Q,
    input  QV,
    input  ERR
  );

  modport slave (
    input  D_1,
    input  D_0,
    output Q,
    output QV,
    output ERR
  );
endinterface
`default_nettype wire

// File: rtl/dr_rx_check.sv
`default_nettype none
// ============================================================================
// Module   : dr_rx_check
// Purpose  : Dual-rail receiver/checker. Decodes codewords that alternate
//            with spacers into a registered single-rail word, and flags,
//            counts and latches protocol violations for the fault monitor.
// Revision : 1.0 - initial release
// ============================================================================
module dr_rx_check #(
  parameter int W        = 8,
  parameter int CNT_W    = 8,
  parameter int ALARM_TH = 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             SP,
  input  logic             EN,
  input  logic             CLR,
  dr_rx_check_if.slave     bus,
  output logic             ALARM,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_alarm_th = ALARM_TH[CNT_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXP_CW  = 2'd1,
    S_EXP_SPC = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sp_q;
  logic [W-1:0]     q_q, q_d;
  logic             qv_q, qv_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q, alarm_d;

  // Bus classification against the live spacer polarity: every bit must be
  // the spacer value on both rails, or every bit must have differing rails.
  // Anything else (mixed, or an anti-spacer bit) is illegal.
  logic [W-1:0] w_bit_spc;
  logic [W-1:0] w_bit_cw;
  logic         w_all_spc;
  logic         w_all_cw;
  logic         w_sp_changed;

  assign w_bit_spc    = ~(bus.D_1 ^ {W{SP}}) & ~(bus.D_0 ^ {W{SP}});
  assign w_bit_cw     = bus.D_1 ^ bus.D_0;
  assign w_all_spc    = &w_bit_spc;
  assign w_all_cw     = &w_bit_cw;
  assign w_sp_changed = (SP != sp_q);

  // Protocol FSM and decode: next state plus the strobes and data for this edge.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qv_d    = 1'b0;
    err_d   = 1'b0;
    if (!EN || w_sp_changed) begin
      // Disabled or polarity just moved: drop sync silently.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_all_spc) state_d = S_EXP_CW;
        end
        S_EXP_CW: begin
          if (w_all_spc) begin
            state_d = S_EXP_CW;
          end else if (w_all_cw) begin
            q_d     = bus.D_1;
            qv_d    = 1'b1;
            state_d = S_EXP_SPC;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXP_SPC: begin
          if (w_all_spc) begin
            state_d = S_EXP_CW;
          end else begin
            // Back-to-back codeword or illegal symbol; Q is left alone.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Error counter and sticky alarm: clear first, then count this edge's error.
  always_comb begin
    cnt_d   = CLR ? '0 : cnt_q;
    alarm_d = CLR ? 1'b0 : alarm_q;
    if (err_d) begin
      if (cnt_d != c_cnt_max) cnt_d = cnt_d + 1'b1;
      if (cnt_d >= c_alarm_th) alarm_d = 1'b1;
    end
  end

  // State and spacer-polarity registers; reset samples the live polarity.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= S_IDLE;
      sp_q    <= SP;
    end else begin
      state_q <= state_d;
      sp_q    <= SP;
    end
  end

  // Registered outputs: decoded word, strobes, counter and alarm.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      q_q     <= '0;
      qv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      qv_q    <= qv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.QV  = qv_q;
  assign bus.ERR = err_q;
  assign ERR_CNT = cnt_q;
  assign ALARM   = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_dr_rx_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_dr_rx_check
// Purpose  : Self-checking bench for dr_rx_check (W=8, CNT_W=2, ALARM_TH=2):
//            directed scenarios followed by random symbol traffic, all
//            compared against a symbol-level protocol model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dr_rx_check;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       SP = 1'b0;
  logic       EN = 1'b1;
  logic       CLR = 1'b0;
  logic       ALARM;
  logic [1:0] ERR_CNT;

  int total = 0;
  int bad   = 0;

  dr_rx_check_if #(.W(8)) bus ();

  dr_rx_check #(.W(8), .CNT_W(2), .ALARM_TH(2)) dut (
    .C       (C),
    .R       (R),
    .SP      (SP),
    .EN      (EN),
    .CLR     (CLR),
    .bus     (bus),
    .ALARM   (ALARM),
    .ERR_CNT (ERR_CNT)
  );

  always #5 C = ~C;

  // ---------------- reference model (symbol level) ----------------
  bit         m_synced;     // a spacer has been seen since last loss of sync
  bit         m_last_cw;    // most recent accepted symbol was a codeword
  logic [7:0] m_q;
  bit         m_qv, m_err, m_alarm;
  int         m_cnt;
  logic       m_sp;

  // 0 = all spacer, 1 = all codeword, 2 = illegal
  function automatic int bus_kind(logic [7:0] d1, logic [7:0] d0, logic sp);
    int nspc = 0;
    int ncw  = 0;
    for (int i = 0; i < 8; i++) begin
      if (d1[i] != d0[i]) ncw++;
      else if (d1[i] == sp) nspc++;
    end
    if (nspc == 8) return 0;
    if (ncw == 8) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_synced = 0; m_last_cw = 0;
    m_q = 8'h00; m_qv = 0; m_err = 0; m_alarm = 0; m_cnt = 0;
    m_sp = SP;
  endtask

  task automatic model_edge();
    int k;
    k = bus_kind(bus.D_1, bus.D_0, SP);
    m_qv = 0; m_err = 0;
    if (!EN || SP !== m_sp) begin
      m_synced = 0; m_last_cw = 0;
    end else if (!m_synced) begin
      if (k == 0) m_synced = 1;
    end else if (k == 0) begin
      m_last_cw = 0;
    end else if (k == 1 && !m_last_cw) begin
      m_q = bus.D_1; m_qv = 1; m_last_cw = 1;
    end else begin
      m_err = 1; m_synced = 0; m_last_cw = 0;
    end
    if (CLR) begin m_cnt = 0; m_alarm = 0; end
    if (m_err) begin
      if (m_cnt < 3) m_cnt++;
      if (m_cnt >= 2) m_alarm = 1;
    end
    m_sp = SP;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("Q", 32'(bus.Q), 32'(m_q));
    chk("QV", 32'(bus.QV), 32'(m_qv));
    chk("ERR", 32'(bus.ERR), 32'(m_err));
    chk("ERR_CNT", 32'(ERR_CNT), 32'(m_cnt));
    chk("ALARM", 32'(ALARM), 32'(m_alarm));
    chk("QV_ERR_excl", 32'(bus.QV & bus.ERR), 32'd0);
  endtask

  // Called at a negedge: drive, clock, check, return at the next negedge.
  task automatic step(input logic [7:0] d1, input logic [7:0] d0);
    bus.D_1 = d1;
    bus.D_0 = d0;
    @(posedge C);
    model_edge();
    #1;
    check_all();
    @(negedge C);
  endtask

  task automatic step_spc();
    step({8{SP}}, {8{SP}});
  endtask

  task automatic step_cw(input logic [7:0] v);
    step(v, ~v);
  endtask

  // Asserts R just after a negedge and releases it one cycle later.
  task automatic do_reset();
    R = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge C);
    R = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int         kind;
    int         b;

    bus.D_1 = 8'h00;
    bus.D_0 = 8'h00;
    #2 R = 1'b1;
    model_reset();
    repeat (2) @(posedge C);
    #1;
    check_all();
    @(negedge C);
    R = 1'b0;

    // Basic decode, SP=0
    step_spc();
    step_cw(8'hA5);
    chk("Q_A5", 32'(bus.Q), 32'h0000_00A5);
    step_spc();
    step_cw(8'h3C);
    chk("Q_3C", 32'(bus.Q), 32'h0000_003C);

    // Unsynchronised start
    do_reset();
    step_cw(8'h11);
    step_spc();
    step_cw(8'h22);
    chk("Q_22", 32'(bus.Q), 32'h0000_0022);

    // Violations
    do_reset();
    step_spc();
    step_cw(8'h01);
    step_cw(8'h02);
    step_spc();
    step(8'h08, 8'hFF);           // bit 3 anti-spacer, rest codeword
    chk("viol_cnt", 32'(ERR_CNT), 32'd2);
    chk("viol_alarm", 32'(ALARM), 32'd1);
    chk("viol_q", 32'(bus.Q), 32'h0000_0001);

    // SP=1 then switch back to SP=0 while the old spacer is on the bus
    SP = 1'b1;
    step_spc();
    step_spc();
    step_cw(8'hFF);
    step_spc();
    SP = 1'b0;
    step(8'hFF, 8'hFF);
    step_spc();
    step_cw(8'h80);
    chk("Q_80", 32'(bus.Q), 32'h0000_0080);

    // Saturation, CLR with a simultaneous error, EN=0
    for (int i = 0; i < 5; i++) begin
      step_spc();
      step(8'h08, 8'hFF);
    end
    chk("sat_cnt", 32'(ERR_CNT), 32'd3);
    step_spc();
    CLR = 1'b1;
    step(8'h08, 8'hFF);
    CLR = 1'b0;
    chk("clr_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("clr_err_alarm", 32'(ALARM), 32'd0);
    EN = 1'b0;
    step_spc();
    step(8'h0F, 8'h0F);
    step(8'hF0, 8'h00);
    EN = 1'b1;
    chk("en_hold_cnt", 32'(ERR_CNT), 32'd1);

    // Async reset between a spacer and a codeword
    step_spc();
    step_cw(8'h5A);
    step_spc();
    #2;
    do_reset();
    step_cw(8'h55);
    step_spc();
    step_cw(8'h66);
    chk("Q_66", 32'(bus.Q), 32'h0000_0066);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      EN  = ($urandom_range(0, 19) != 0);
      CLR = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0) SP = ~SP;
      kind = int'($urandom_range(0, 9));
      v    = 8'($urandom);
      if (kind <= 3) begin
        step_spc();
      end else if (kind <= 7) begin
        step_cw(v);
      end else if (kind == 8) begin
        b = int'($urandom_range(0, 7));
        begin
          logic [7:0] d1;
          logic [7:0] d0;
          d1 = v; d0 = ~v;
          d1[b] = ~SP; d0[b] = ~SP;
          step(d1, d0);
        end
      end else begin
        step(8'($urandom), 8'($urandom));
      end
    end
    EN  = 1'b1;
    CLR = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dr_rx_check.md
# dr_rx_check

Dual-rail receiver and checker at the consuming end of dual-rail register chains built from the `_0dr` flip-flop and latch cells. It samples a W-bit dual-rail bus (`D_1`/`D_0`) that alternates between a spacer and a codeword. It converts each valid codeword to a registered single-rail word with a one-cycle valid strobe. It also enforces the spacer/codeword protocol, flagging illegal symbols, counting errors and raising a sticky alarm for the security/fault monitor.

## Interface
Parameters:
- `W`, default 8: dual-rail bus width in bits.
- `CNT_W`, default 8: width of the error counter.
- `ALARM_TH`, default 1: error count at which `ALARM` sets. Range 1..2^CNT_W-1.

Ports:
- `C`, in, 1: clock, rising edge.
- `R`, in, 1: reset, asynchronous, active-high.
- `SP`, in, 1: spacer polarity. 0 means all-zero spacer (00); 1 means all-one spacer (11). Quasi-static.
- `EN`, in, 1: checker enable.
- `CLR`, in, 1: synchronous clear of `ERR_CNT` and `ALARM`.
- `D_1`, in, W: true rails.
- `D_0`, in, W: false rails.
- `Q`, out, W: decoded single-rail data.
- `QV`, out, 1: one-cycle strobe; `Q` updated.
- `ERR`, out, 1: one-cycle strobe; protocol violation detected.
- `ALARM`, out, 1: sticky alarm.
- `ERR_CNT`, out, CNT_W: saturating violation count.

## Operation
- Per-bit classification, against the current `SP`:
  - spacer (SPC): `D_1 == D_0 == SP`.
  - codeword (CW): `D_1 != D_0`, value = `D_1`.
  - anti-spacer (ASP): `D_1 == D_0 != SP`.
- Bus classification:
  - ALL_SPC: every bit is SPC.
  - ALL_CW: every bit is CW.
  - otherwise ILLEGAL (mixed, or any ASP bit).
- FSM states: IDLE, EXP_CW, EXP_SPC. Reset state is IDLE.
- IDLE (unsynchronised):
  - ALL_SPC goes to EXP_CW.
  - Anything else stays in IDLE, with no `ERR`.
- EXP_CW:
  - ALL_SPC stays in EXP_CW (bus idle; spacers may repeat indefinitely).
  - ALL_CW registers `Q <= D_1`, asserts `QV`, and goes to EXP_SPC.
  - ILLEGAL asserts `ERR` and goes to IDLE.
- EXP_SPC:
  - ALL_SPC goes to EXP_CW.
  - ALL_CW asserts `ERR` and goes to IDLE; `Q` is not updated, because back-to-back codewords are illegal.
  - ILLEGAL asserts `ERR` and goes to IDLE.
- `EN = 0`:
  - Next state is IDLE.
  - `QV` and `ERR` stay 0; `Q`, `ERR_CNT` and `ALARM` hold.
  - `CLR` still acts.
- `SP` change: `SP` is registered internally. If the registered and current values differ in a cycle, the FSM goes to IDLE with no `ERR` and no `QV`, whatever the bus value.
- Error counting:
  - Each `ERR` pulse increments `ERR_CNT`, saturating at 2^CNT_W-1.
  - `ALARM` sets on the edge where the incremented count is ≥ `ALARM_TH`, and stays set until `CLR` or `R`.
- `CLR` with a simultaneous error:
  - `CLR` applies first, then the error is counted, so `ERR_CNT` becomes 1.
  - `ALARM` becomes (1 ≥ `ALARM_TH`).
- `Q` holds its last decoded value between strobes and is never driven from spacer data.

## Timing
- All outputs are registered.
- Bus sampled at edge k: `Q`, `QV` and `ERR` are valid after edge k and stay so for one cycle. Latency is 1.
- `ERR_CNT` and `ALARM` update on the same edge as the corresponding `ERR`.
- `R` asserted, asynchronously:
  - `Q = 0`, `QV = 0`, `ERR = 0`, `ALARM = 0`, `ERR_CNT = 0`.
  - FSM goes to IDLE; registered `SP` takes the current `SP` value.
- `R` mid-frame: any partially received symbol is discarded. After release, a full spacer is required before the first codeword is accepted.
- Maximum throughput: one codeword every 2 cycles (CW, SPC, CW, ...).
- `QV` and `ERR` are never high in the same cycle.

## Test plan
- W=8, SP=0:
  - Stimulus: reset, then bus sequence SPC, CW 0xA5, SPC, CW 0x3C.
  - Response: `QV` high 1 cycle after each CW; `Q` = 0xA5, then 0x3C. `ERR` stays 0; `ERR_CNT` = 0.
- Unsynchronised start:
  - Stimulus: after reset, CW 0x11 then SPC then CW 0x22.
  - Response: first CW ignored with no `ERR`; only `Q` = 0x22 strobed.
- Violations, SP=0, ALARM_TH=2:
  - Stimulus: synced; CW 0x01, CW 0x02 (back-to-back); then resync; then a bus with bit 3 = 11 (ASP).
  - Response: `ERR` pulses twice; `ERR_CNT` 1 then 2; `ALARM` rises with the second `ERR`; `Q` stays 0x01.
- SP=1 and SP switch:
  - Stimulus: SP=1, spacer all 11, CW 0xFF strobes correctly. Then flip SP to 0 mid-stream and drive the old spacer 11.
  - Response: FSM goes to IDLE with no `ERR`. The next all-00 spacer resyncs, and CW 0x80 strobes.
- CLR, saturation, EN:
  - Stimulus (CNT_W=2): drive 5 errors; then `CLR` together with an error; then `EN=0` while driving illegal symbols.
  - Response: `ERR_CNT` saturates at 3. `CLR` with the error gives `ERR_CNT` = 1. With `EN=0` there is no `ERR` and counts hold.
- Async reset mid-operation:
  - Stimulus: assert `R` between a spacer and a codeword, away from a clock edge.
  - Response: all outputs reset immediately. After release, a CW before any spacer is ignored.
